// File: rtl/classify_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : classify_ctrl
//  Purpose  : Sequencer for the k-means classification datapath
//             (pipe1 distance, pipe2 argmin, pipe3 accumulate). Per iteration
//             it loads centroids (first iteration only), clears the
//             accumulators, streams N points from data RAM, drains the
//             pipeline, starts the new-means block, walks the centroid
//             update and waits for the convergence verdict.
//  Ports    : clk, rst (sync, active-high)
//             start/num_points/k_num/max_iter   run request (sampled in IDLE)
//             ram_addr/ram_rd_en                 data RAM read port
//             ram_input_reg_en/accumulators_en   pipe1 load / pipe3 enable
//             centroid_en/first_iteration        centroid load control
//             pipe3_regs_reset_n                 active-low accumulator clear
//             calc_start/calc_done               new-means handshake
//             cent_cnt/cent_upd_en               centroid update walk
//             conv_valid/converged               convergence verdict
//             busy/done                          status
//  Options  : CLASSIFY_CTRL_RAM_STALL_EN adds input ram_stall, which holds
//             the point stream (no read, address holds) while high.
//  Revision : 1.0  initial release
// ============================================================================
module classify_ctrl #(
    parameter int addrWidth    = 8,
    parameter int count_width  = 10,
    parameter int centroid_num = 8,
    parameter int PIPE_LAT     = 3,
    parameter int iter_width   = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [count_width-1:0]  num_points,
    input  logic [2:0]              k_num,
    input  logic [iter_width-1:0]   max_iter,
    input  logic                    calc_done,
    input  logic                    conv_valid,
    input  logic                    converged,
`ifdef CLASSIFY_CTRL_RAM_STALL_EN
    input  logic                    ram_stall,
`endif
    output logic [addrWidth-1:0]    ram_addr,
    output logic                    ram_rd_en,
    output logic                    ram_input_reg_en,
    output logic [centroid_num-1:0] centroid_en,
    output logic                    first_iteration,
    output logic                    pipe3_regs_reset_n,
    output logic                    accumulators_en,
    output logic                    calc_start,
    output logic [2:0]              cent_cnt,
    output logic                    cent_upd_en,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD_CENT = 4'd1,
        S_CLR_ACC   = 4'd2,
        S_STREAM    = 4'd3,
        S_DRAIN     = 4'd4,
        S_CALC      = 4'd5,
        S_UPDATE    = 4'd6,
        S_CONV      = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    localparam logic [centroid_num-1:0] c_cen_one = {{(centroid_num-1){1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_state_next;
    logic [count_width-1:0]  r_n;
    logic [2:0]              r_k;
    logic [iter_width-1:0]   r_max_iter;
    logic [iter_width-1:0]   r_iter;
    logic [count_width-1:0]  r_pcnt;
    logic [2:0]              r_idx;
    logic                    r_first;
    logic                    r_rd_dly;
    logic [PIPE_LAT-1:0]     r_vsr;
    logic                    r_calc_sent;

    logic                    w_stall;
    logic                    w_last_pt;
    logic                    w_idx_last;
    logic [iter_width-1:0]   w_iter_inc;
    logic                    w_finish;

`ifdef CLASSIFY_CTRL_RAM_STALL_EN
    assign w_stall = ram_stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_last_pt  = (r_pcnt == (r_n - 1'b1));
    assign w_idx_last = (r_idx == r_k);
    assign w_iter_inc = r_iter + 1'b1;
    // Stop on a converged verdict or when the iteration budget is used up;
    // max_iter of zero means run until convergence.
    assign w_finish   = converged || ((r_max_iter != '0) && (w_iter_inc == r_max_iter));

    assign ram_input_reg_en = r_rd_dly;
    assign accumulators_en  = r_vsr[PIPE_LAT-1];
    assign first_iteration  = r_first;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_k         <= '0;
            r_max_iter  <= '0;
            r_iter      <= '0;
            r_pcnt      <= '0;
            r_idx       <= '0;
            r_first     <= 1'b0;
            r_rd_dly    <= 1'b0;
            r_vsr       <= '0;
            r_calc_sent <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            // RAM data arrives one cycle after the read strobe; the valid
            // shift register then tracks each point through the pipes.
            r_rd_dly <= ram_rd_en;
            r_vsr[0] <= r_rd_dly;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_vsr[i] <= r_vsr[i-1];
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n        <= num_points;
                        r_k        <= k_num;
                        r_max_iter <= max_iter;
                        r_iter     <= '0;
                        r_idx      <= '0;
                        r_first    <= 1'b1;
                    end
                end
                S_LOAD_CENT: begin
                    r_idx <= w_idx_last ? 3'd0 : r_idx + 3'd1;
                end
                S_CLR_ACC: begin
                    r_first <= 1'b0;
                    r_pcnt  <= '0;
                end
                S_STREAM: begin
                    if (!w_stall) begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_calc_sent <= 1'b0;
                end
                S_CALC: begin
                    r_calc_sent <= 1'b1;
                end
                S_UPDATE: begin
                    r_idx <= w_idx_last ? 3'd0 : r_idx + 3'd1;
                end
                S_CONV: begin
                    if (conv_valid && !w_finish) begin
                        r_iter <= w_iter_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        ram_addr           = '0;
        ram_rd_en          = 1'b0;
        centroid_en        = '0;
        pipe3_regs_reset_n = 1'b1;
        calc_start         = 1'b0;
        cent_cnt           = 3'd0;
        cent_upd_en        = 1'b0;
        busy               = 1'b1;
        done               = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = S_LOAD_CENT;
                end
            end
            S_LOAD_CENT: begin
                centroid_en = c_cen_one << r_idx;
                if (w_idx_last) begin
                    w_state_next = S_CLR_ACC;
                end
            end
            S_CLR_ACC: begin
                pipe3_regs_reset_n = 1'b0;
                w_state_next       = S_STREAM;
            end
            S_STREAM: begin
                ram_addr = r_pcnt[addrWidth-1:0];
                if (!w_stall) begin
                    ram_rd_en = 1'b1;
                    if (w_last_pt) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave only once every issued point has left pipe3.
                if (!r_rd_dly && (r_vsr == '0)) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                calc_start = !r_calc_sent;
                if (calc_done) begin
                    w_state_next = S_UPDATE;
                end
            end
            S_UPDATE: begin
                cent_cnt    = r_idx;
                cent_upd_en = 1'b1;
                if (w_idx_last) begin
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                if (conv_valid) begin
                    w_state_next = w_finish ? S_DONE : S_CLR_ACC;
                end
            end
            S_DONE: begin
                busy         = 1'b0;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_classify_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_classify_ctrl
//  Purpose  : Scoreboard bench for classify_ctrl. Expected address, centroid
//             load and centroid update sequences are queued when a run is
//             requested and consumed by a negedge monitor.
//  Options  : CLASSIFY_CTRL_RAM_STALL_EN enables the ram_stall scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_classify_ctrl;

    localparam int AW = 8;
    localparam int CW = 10;
    localparam int CN = 8;
    localparam int PL = 3;
    localparam int IW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] num_points = '0;
    logic [2:0]    k_num = '0;
    logic [IW-1:0] max_iter = '0;
    logic          calc_done = 1'b0;
    logic          conv_valid = 1'b0;
    logic          converged = 1'b0;
`ifdef CLASSIFY_CTRL_RAM_STALL_EN
    logic          ram_stall = 1'b0;
`endif
    logic [AW-1:0] ram_addr;
    logic          ram_rd_en;
    logic          ram_input_reg_en;
    logic [CN-1:0] centroid_en;
    logic          first_iteration;
    logic          pipe3_regs_reset_n;
    logic          accumulators_en;
    logic          calc_start;
    logic [2:0]    cent_cnt;
    logic          cent_upd_en;
    logic          busy;
    logic          done;

    classify_ctrl #(
        .addrWidth(AW), .count_width(CW), .centroid_num(CN),
        .PIPE_LAT(PL), .iter_width(IW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_points(num_points),
        .k_num(k_num), .max_iter(max_iter), .calc_done(calc_done),
        .conv_valid(conv_valid), .converged(converged),
`ifdef CLASSIFY_CTRL_RAM_STALL_EN
        .ram_stall(ram_stall),
`endif
        .ram_addr(ram_addr), .ram_rd_en(ram_rd_en),
        .ram_input_reg_en(ram_input_reg_en), .centroid_en(centroid_en),
        .first_iteration(first_iteration),
        .pipe3_regs_reset_n(pipe3_regs_reset_n),
        .accumulators_en(accumulators_en), .calc_start(calc_start),
        .cent_cnt(cent_cnt), .cent_upd_en(cent_upd_en),
        .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor-owned event counters
    int cyc = 0, n_acc = 0, n_clr = 0, n_calc = 0, n_done = 0, n_upd = 0;
    int t_rd_rise = 0, t_acc_rise = 0, fi_stream_bad = 0, fi_load_bad = 0;
    logic [7:0] fi_hist = '0;

    int q_addr[$];
    int q_cen[$];
    int q_cnt[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer
    initial begin
        logic prev_rd, prev_acc;
        prev_rd  = 1'b0;
        prev_acc = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (ram_rd_en) begin
                    if (q_addr.size() == 0) check("addr_unexpected", 32'd1, 32'd0);
                    else check("ram_addr", 32'(ram_addr), q_addr.pop_front());
                    if (!prev_rd) begin
                        t_rd_rise = cyc;
                        if (first_iteration) fi_stream_bad++;
                    end
                end
                if (centroid_en != '0) begin
                    if (q_cen.size() == 0) check("cen_unexpected", 32'd1, 32'd0);
                    else check("centroid_en", 32'(centroid_en), q_cen.pop_front());
                    if (!first_iteration) fi_load_bad++;
                end
                if (cent_upd_en) begin
                    n_upd++;
                    if (q_cnt.size() == 0) check("cnt_unexpected", 32'd1, 32'd0);
                    else check("cent_cnt", 32'(cent_cnt), q_cnt.pop_front());
                end
                if (accumulators_en) begin
                    n_acc++;
                    if (!prev_acc) t_acc_rise = cyc;
                end
                if (!pipe3_regs_reset_n) begin
                    n_clr++;
                    fi_hist = {fi_hist[6:0], first_iteration};
                    check("acc_during_clr", 32'(accumulators_en), 32'd0);
                end
                if (calc_start) n_calc++;
                if (done) n_done++;
            end
            prev_rd  = ram_rd_en;
            prev_acc = accumulators_en;
        end
    end

    task automatic push_run(input int n, input int k, input int iters);
        for (int i = 0; i <= k; i++) q_cen.push_back(1 << i);
        for (int it = 0; it < iters; it++) begin
            for (int a = 0; a < n; a++) q_addr.push_back(a % (1 << AW));
            for (int c = 0; c <= k; c++) q_cnt.push_back(c);
        end
    endtask

    task automatic do_start(input int n, input int k, input int m);
        @(posedge clk); #1;
        num_points = CW'(n);
        k_num      = 3'(k);
        max_iter   = IW'(m);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        i = 0;
        while (done !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(done === 1'b1), 32'd1);
    endtask

    task automatic wait_addr(input string tag, input int a, input int budget);
        int i;
        i = 0;
        while (!(ram_rd_en === 1'b1 && ram_addr == AW'(a)) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(ram_rd_en === 1'b1 && ram_addr == AW'(a)), 32'd1);
    endtask

    task automatic check_idle(input string p);
        check({p, "_addr"}, 32'(ram_addr), 32'd0);
        check({p, "_rd"}, 32'(ram_rd_en), 32'd0);
        check({p, "_ireg"}, 32'(ram_input_reg_en), 32'd0);
        check({p, "_cen"}, 32'(centroid_en), 32'd0);
        check({p, "_first"}, 32'(first_iteration), 32'd0);
        check({p, "_rstn"}, 32'(pipe3_regs_reset_n), 32'd1);
        check({p, "_acc"}, 32'(accumulators_en), 32'd0);
        check({p, "_calc"}, 32'(calc_start), 32'd0);
        check({p, "_cnt"}, 32'(cent_cnt), 32'd0);
        check({p, "_upd"}, 32'(cent_upd_en), 32'd0);
        check({p, "_busy"}, 32'(busy), 32'd0);
        check({p, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic check_queues(input string p);
        check({p, "_q_empty"}, 32'(q_addr.size() + q_cen.size() + q_cnt.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int s_acc, s_clr, s_calc, s_done, s_upd, i;

        // ---------------- reset values ----------------
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- S1: k=4, N=5, converge at once ----------------
        calc_done = 1'b1; conv_valid = 1'b1; converged = 1'b1;
        s_acc = n_acc; s_clr = n_clr; s_calc = n_calc; s_done = n_done;
        push_run(5, 3, 1);
        do_start(5, 3, 0);
        wait_done("s1_done_seen", 300);
        @(negedge clk);
        check("s1_done_1cyc", 32'(done), 32'd0);
        check("s1_busy_after", 32'(busy), 32'd0);
        check("s1_acc_cnt", n_acc - s_acc, 5);
        check("s1_acc_lat", t_acc_rise - t_rd_rise, PL + 1);
        check("s1_clr_cnt", n_clr - s_clr, 1);
        check("s1_calc_cnt", n_calc - s_calc, 1);
        check("s1_done_cnt", n_done - s_done, 1);
        check_queues("s1");

        // ---------------- S2: never converges, max_iter=3 ----------------
        converged = 1'b0;
        s_acc = n_acc; s_clr = n_clr; s_done = n_done; s_upd = n_upd;
        push_run(3, 1, 3);
        do_start(3, 1, 3);
        wait_done("s2_done_seen", 600);
        @(negedge clk);
        check("s2_clr_cnt", n_clr - s_clr, 3);
        check("s2_acc_cnt", n_acc - s_acc, 9);
        check("s2_upd_cnt", n_upd - s_upd, 6);
        check("s2_done_cnt", n_done - s_done, 1);
        check("s2_first_later_clr", 32'(fi_hist[1:0]), 32'd0);
        check("s2_first_in_stream", fi_stream_bad, 0);
        check("s2_first_in_load", fi_load_bad, 0);
        check_queues("s2");

        // ---------------- S3: calc_done held off ----------------
        converged = 1'b1; calc_done = 1'b0;
        s_calc = n_calc; s_upd = n_upd;
        push_run(4, 2, 1);
        do_start(4, 2, 0);
        i = 0;
        while (calc_start !== 1'b1 && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("s3_calc_seen", 32'(calc_start), 32'd1);
        repeat (10) @(negedge clk);
        check("s3_no_upd", n_upd - s_upd, 0);
        check("s3_calc_once", n_calc - s_calc, 1);
        check("s3_busy_wait", 32'(busy), 32'd1);
        @(posedge clk); #1;
        calc_done = 1'b1;
        wait_done("s3_done_seen", 100);
        @(negedge clk);
        check("s3_upd_cnt", n_upd - s_upd, 3);
        check_queues("s3");

        // ---------------- S4: reset mid-stream, then replay ----------------
        push_run(8, 0, 1);
        do_start(8, 0, 0);
        wait_addr("s4_addr2_seen", 2, 100);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("s4_rst");
        q_addr.delete(); q_cen.delete(); q_cnt.delete();
        s_acc = n_acc;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("s4_no_acc", n_acc - s_acc, 0);
        check("s4_idle_busy", 32'(busy), 32'd0);
        s_acc = n_acc; s_done = n_done;
        push_run(3, 1, 1);
        do_start(3, 1, 0);
        wait_done("s4_replay_done", 300);
        @(negedge clk);
        check("s4_replay_acc", n_acc - s_acc, 3);
        check("s4_replay_done_cnt", n_done - s_done, 1);
        check_queues("s4");

        // ---------------- S5: start while busy ----------------
        s_acc = n_acc; s_done = n_done; s_clr = n_clr;
        push_run(6, 1, 1);
        do_start(6, 1, 0);
        wait_addr("s5_addr1_seen", 1, 100);
        do_start(2, 0, 5);
        wait_done("s5_done_seen", 300);
        @(negedge clk);
        check("s5_acc_cnt", n_acc - s_acc, 6);
        check("s5_clr_cnt", n_clr - s_clr, 1);
        check("s5_done_cnt", n_done - s_done, 1);
        check_queues("s5");

`ifdef CLASSIFY_CTRL_RAM_STALL_EN
        // ---------------- S6: RAM stall ----------------
        s_acc = n_acc;
        push_run(4, 0, 1);
        do_start(4, 0, 0);
        wait_addr("s6_addr1_seen", 1, 100);
        @(posedge clk); #1;
        ram_stall = 1'b1;
        @(negedge clk);
        check("s6_stall_rd", 32'(ram_rd_en), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ram_stall = 1'b0;
        @(negedge clk);
        check("s6_resume_rd", 32'(ram_rd_en), 32'd1);
        check("s6_resume_addr", 32'(ram_addr), 32'd2);
        wait_done("s6_done_seen", 200);
        @(negedge clk);
        check("s6_acc_cnt", n_acc - s_acc, 4);
        check_queues("s6");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/classify_ctrl.md
Name: classify_ctrl

Overview:
- Sequencer for the k-means classification datapath (pipe1 distance, pipe2 argmin, pipe3 accumulate).
- Per iteration: loads initial centroids on the first iteration; clears the accumulators; streams N points from data RAM; drains the pipeline; hands off to the new-means block; walks the centroid update; waits for the convergence verdict.
- Sits between the top-level k-means core FSM and classification_block, driving all of that block's control inputs.

Parameters:
- addrWidth, 8, RAM address width.
- count_width, 10, point-count width.
- centroid_num, 8, maximum centroids; one-hot centroid_en width.
- PIPE_LAT, 3, cycles from ram_input_reg_en to the matching accumulators_en. Legal values 1..7.
- iter_width, 6, iteration-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run. Accepted only in IDLE.
- num_points  in  count_width  N points, 1..2^count_width-1. Sampled on start.
- k_num  in  3  centroids minus one (0 means k=1). Sampled on start.
- max_iter  in  iter_width  iteration limit; 0 means unlimited. Sampled on start.
- ram_addr  out  addrWidth  data RAM read address.
- ram_rd_en  out  1  RAM read strobe. Read data is valid the next cycle.
- ram_input_reg_en  out  1  pipe1 point-register load.
- centroid_en  out  centroid_num  one-hot centroid register load from the regfile.
- first_iteration  out  1  high from start until the first CLR_ACC.
- pipe3_regs_reset_n  out  1  active-low accumulator/count clear.
- accumulators_en  out  1  pipe3 accumulate enable.
- calc_start  out  1  one-cycle pulse to the new-means block.
- calc_done  in  1  new means ready.
- cent_cnt  out  3  centroid index for update/convergence.
- cent_upd_en  out  1  new_centroid write strobe for centroid cent_cnt.
- conv_valid  in  1  convergence verdict valid.
- converged  in  1  verdict; sampled when conv_valid=1.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset, and any cycle with rst=1: state=IDLE; all counters 0; valid shift register cleared.
- Output reset values: all outputs 0, except pipe3_regs_reset_n=1.
- rst overrides everything, mid-run included. No partial pulses are emitted after rst.
- IDLE: on start, latch N, k, max_iter; set first_iteration=1; go to LOAD_CENT.
- LOAD_CENT: one centroid per cycle.
  - centroid_en = 1<<idx, for idx = 0..k_num.
  - Regfile data is combinational.
  - After idx=k_num, go to CLR_ACC.
- CLR_ACC: exactly 1 cycle.
  - pipe3_regs_reset_n=0; first_iteration cleared; point counter reset.
  - Go to STREAM.
- STREAM:
  - Each cycle: ram_rd_en=1, ram_addr=pcnt; pcnt increments.
  - After pcnt=N-1 is issued, go to DRAIN.
  - ram_input_reg_en is ram_rd_en delayed 1 cycle.
- Valid pipeline:
  - A PIPE_LAT-deep shift register is fed by ram_input_reg_en.
  - accumulators_en = its last stage.
  - Exactly N accumulators_en pulses per iteration, and never during CLR_ACC.
- DRAIN: wait until the shift register and the RAM-delay flop are all zero (PIPE_LAT+1 cycles), then go to CALC.
- CALC: pulse calc_start on entry, then wait for calc_done. calc_done asserted in the same cycle as calc_start is accepted.
- UPDATE:
  - cent_cnt steps 0..k_num, one per cycle, with cent_upd_en=1.
  - Then go to CONV with cent_cnt=0.
- CONV: wait for conv_valid.
  - converged=1, or iter+1==max_iter with max_iter≠0: go to DONE.
  - Otherwise increment iter and go to CLR_ACC.
- DONE: done=1 for 1 cycle, then IDLE.
- Address width: ram_addr is pcnt[addrWidth-1:0].
- Counter wrap: iter wraps modulo 2^iter_width when max_iter=0.
- start while busy is ignored.
- k_num=0: LOAD_CENT and UPDATE each last 1 cycle.

Optional Feature:
- Macro: CLASSIFY_CTRL_RAM_STALL_EN.
- Defined:
  - Adds input ram_stall (1 bit).
  - While ram_stall=1 in STREAM: ram_rd_en=0 and pcnt holds. In-flight points continue through the valid pipeline.
  - DRAIN entry still requires all N points issued.
- Undefined: no ram_stall port; STREAM always issues one read per cycle.

Test Plan:
- k_num=3, N=5, max_iter=0, converged=1 on first verdict:
  - centroid_en sequence 0x01,0x02,0x04,0x08.
  - ram_addr 0..4 on consecutive cycles.
  - accumulators_en high for 5 cycles, starting PIPE_LAT+1 cycles after the first ram_rd_en.
  - cent_cnt 0..3; done pulses once.
- N=3, converged=0 always, max_iter=3: three CLR_ACC pulses; first_iteration high only before the first; done after the third verdict.
- calc_done held low 10 cycles: FSM stays in CALC; calc_start pulsed exactly once; no cent_upd_en until calc_done.
- rst asserted mid-STREAM at pcnt=2: next cycle all outputs at reset values; no further accumulators_en; a new start replays cleanly.
- start pulsed during STREAM: ignored; N unchanged; the address sequence continues.
- With CLASSIFY_CTRL_RAM_STALL_EN, N=4, ram_stall high 2 cycles after addr 1: addresses 0,1,(gap 2),2,3; exactly 4 accumulators_en pulses.
